// File: rtl/pending_dispatch_pkg.sv
// Shared constants, FSM encoding and the one-hot to binary encoder
// used by the pending_dispatch request dispatcher.
package pending_dispatch_pkg;

   localparam int WIDTH = 16;
   localparam int IDX_W = 4;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_OFFER = 1'b1
   } state_t;

   // Encode a one-hot (or all-zero) vector into its binary bit position.
   // An all-zero input yields 0.
   function automatic logic [IDX_W-1:0] onehot_to_index(input logic [WIDTH-1:0] oh);
      logic [IDX_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (oh[i]) begin
            idx = idx | IDX_W'(i);
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/first_bit.sv
// Lowest-set-bit isolator: gnt has exactly the lowest set bit of req,
// or is all zero when req is zero.
module first_bit
   import pending_dispatch_pkg::*;
(
   input  logic [WIDTH-1:0] req,
   output logic [WIDTH-1:0] gnt
);

   // seen[i] is high when any bit below position i is set
   logic [WIDTH-1:0] seen;

   assign seen[0] = 1'b0;
   assign gnt[0]  = req[0];

   generate
      for (genvar gi = 1; gi < WIDTH; gi++) begin : g_chain
         assign seen[gi] = seen[gi-1] | req[gi-1];
         assign gnt[gi]  = req[gi] & ~seen[gi];
      end
   endgenerate

endmodule

// File: rtl/pending_dispatch.sv
// Request capture and dispatch: edge-detects request lines into a sticky
// pending register, picks the lowest eligible bit and offers it over a
// valid/ready handshake, clearing the pending bit once it is accepted.
module pending_dispatch
   import pending_dispatch_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [WIDTH-1:0]  event_in,
   input  logic [WIDTH-1:0]  mask,
   input  logic              clear_all,
   input  logic              irq_ready,
   output logic              irq_valid,
   output logic [WIDTH-1:0]  irq_onehot,
   output logic [IDX_W-1:0]  irq_index,
   output logic [WIDTH-1:0]  pending,
   output logic [WIDTH-1:0]  overflow
);

   state_t            state_q,    state_d;
   logic [WIDTH-1:0]  pending_q,  pending_d;
   logic [WIDTH-1:0]  event_d_q,  event_d_d;
   logic [WIDTH-1:0]  overflow_q, overflow_d;
   logic              valid_q,    valid_d;
   logic [WIDTH-1:0]  onehot_q,   onehot_d;
   logic [IDX_W-1:0]  index_q,    index_d;

   logic [WIDTH-1:0]  rise;
   logic [WIDTH-1:0]  acc;
   logic [WIDTH-1:0]  eligible;
   logic [WIDTH-1:0]  winner;

   assign eligible = pending_q & mask;

   first_bit u_first_bit (
      .req (eligible),
      .gnt (winner)
   );

   // Next-state logic: edge capture, pending/overflow update and offer FSM.
   // clear_all overrides rises and ends any offer; a handshake in that
   // cycle is treated as done since the bit is flushed anyway.
   always_comb begin
      rise       = event_in & ~event_d_q;
      acc        = (valid_q && irq_ready) ? onehot_q : '0;
      event_d_d  = event_in;
      pending_d  = (pending_q & ~acc) | rise;
      overflow_d = rise & pending_q & ~acc;
      state_d    = state_q;
      valid_d    = valid_q;
      onehot_d   = onehot_q;
      index_d    = index_q;

      unique case (state_q)
         ST_IDLE: begin
            if (eligible != '0) begin
               valid_d  = 1'b1;
               onehot_d = winner;
               index_d  = onehot_to_index(winner);
               state_d  = ST_OFFER;
            end else begin
               valid_d  = 1'b0;
               onehot_d = '0;
               index_d  = '0;
            end
         end
         ST_OFFER: begin
            // The offer is frozen until taken; mask changes and new rises
            // only affect the next selection.
            if (irq_ready) begin
               valid_d  = 1'b0;
               onehot_d = '0;
               index_d  = '0;
               state_d  = ST_IDLE;
            end
         end
         default: begin
            valid_d  = 1'b0;
            onehot_d = '0;
            index_d  = '0;
            state_d  = ST_IDLE;
         end
      endcase

      if (clear_all) begin
         pending_d  = '0;
         overflow_d = '0;
         valid_d    = 1'b0;
         onehot_d   = '0;
         index_d    = '0;
         state_d    = ST_IDLE;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         pending_q  <= '0;
         event_d_q  <= '0;
         overflow_q <= '0;
         valid_q    <= 1'b0;
         onehot_q   <= '0;
         index_q    <= '0;
      end else begin
         state_q    <= state_d;
         pending_q  <= pending_d;
         event_d_q  <= event_d_d;
         overflow_q <= overflow_d;
         valid_q    <= valid_d;
         onehot_q   <= onehot_d;
         index_q    <= index_d;
      end
   end

   assign irq_valid  = valid_q;
   assign irq_onehot = onehot_q;
   assign irq_index  = index_q;
   assign pending    = pending_q;
   assign overflow   = overflow_q;

endmodule

// File: tb/tb_pending_dispatch.sv
// Directed, table-driven bench for pending_dispatch with a few
// hand-written multi-cycle sequences at the end.
module tb_pending_dispatch;

   logic        clk;
   logic        rst;
   logic [15:0] event_in;
   logic [15:0] mask;
   logic        clear_all;
   logic        irq_ready;
   logic        irq_valid;
   logic [15:0] irq_onehot;
   logic [3:0]  irq_index;
   logic [15:0] pending;
   logic [15:0] overflow;

   int n_vec;
   int n_err;

   typedef struct {
      logic        rst;
      logic        clr;
      logic        rdy;
      logic [15:0] ev;
      logic [15:0] msk;
      logic        e_valid;
      logic [15:0] e_oh;
      logic [3:0]  e_idx;
      logic [15:0] e_pend;
      logic [15:0] e_ovf;
   } vec_t;

   vec_t vecs[$];

   pending_dispatch dut (
      .clk        (clk),
      .rst        (rst),
      .event_in   (event_in),
      .mask       (mask),
      .clear_all  (clear_all),
      .irq_ready  (irq_ready),
      .irq_valid  (irq_valid),
      .irq_onehot (irq_onehot),
      .irq_index  (irq_index),
      .pending    (pending),
      .overflow   (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic add(input logic r, input logic c, input logic y,
                      input logic [15:0] ev, input logic [15:0] m,
                      input logic v, input logic [15:0] oh, input logic [3:0] idx,
                      input logic [15:0] pd, input logic [15:0] ov);
      vec_t t;
      t.rst = r; t.clr = c; t.rdy = y; t.ev = ev; t.msk = m;
      t.e_valid = v; t.e_oh = oh; t.e_idx = idx; t.e_pend = pd; t.e_ovf = ov;
      vecs.push_back(t);
   endtask

   task automatic chk(input int id, input string nm, input logic [15:0] act, input logic [15:0] exp);
      if (act !== exp) begin
         n_err++;
         $display("FAIL vec %0d %s: got %h expected %h", id, nm, act, exp);
      end
   endtask

   task automatic chk_all(input int id, input logic v, input logic [15:0] oh,
                          input logic [3:0] idx, input logic [15:0] pd, input logic [15:0] ov);
      n_vec++;
      chk(id, "irq_valid",  {15'd0, irq_valid}, {15'd0, v});
      chk(id, "irq_onehot", irq_onehot, oh);
      chk(id, "irq_index",  {12'd0, irq_index}, {12'd0, idx});
      chk(id, "pending",    pending, pd);
      chk(id, "overflow",   overflow, ov);
      $display("vec %0d: valid=%b onehot=%h index=%0d pending=%h overflow=%h",
               id, irq_valid, irq_onehot, irq_index, pending, overflow);
   endtask

   localparam logic [15:0] F = 16'hFFFF;

   initial begin
      bit got;
      rst = 1'b1; clear_all = 1'b0; irq_ready = 1'b0;
      event_in = '0; mask = F;
      n_vec = 0; n_err = 0;

      // reset and quiet period
      add(1,0,0,16'h0000,F, 0,16'h0000,0, 16'h0000,16'h0000);
      for (int i = 0; i < 5; i++) add(0,0,0,16'h0000,F, 0,16'h0000,0, 16'h0000,16'h0000);
      // single request on bit 5, held offer, then accept
      add(0,0,0,16'h0020,F, 0,16'h0000,0, 16'h0020,16'h0000);
      for (int i = 0; i < 10; i++) add(0,0,0,16'h0020,F, 1,16'h0020,5, 16'h0020,16'h0000);
      add(0,0,1,16'h0020,F, 0,16'h0000,0, 16'h0000,16'h0000);
      for (int i = 0; i < 3; i++) add(0,0,0,16'h0020,F, 0,16'h0000,0, 16'h0000,16'h0000);
      add(0,0,0,16'h0000,F, 0,16'h0000,0, 16'h0000,16'h0000);
      // priority drain with ready held high
      add(0,0,1,16'h4208,F, 0,16'h0000,0,  16'h4208,16'h0000);
      add(0,0,1,16'h4208,F, 1,16'h0008,3,  16'h4208,16'h0000);
      add(0,0,1,16'h4208,F, 0,16'h0000,0,  16'h4200,16'h0000);
      add(0,0,1,16'h4208,F, 1,16'h0200,9,  16'h4200,16'h0000);
      add(0,0,1,16'h4208,F, 0,16'h0000,0,  16'h4000,16'h0000);
      add(0,0,1,16'h4208,F, 1,16'h4000,14, 16'h4000,16'h0000);
      add(0,0,1,16'h4208,F, 0,16'h0000,0,  16'h0000,16'h0000);
      add(0,0,1,16'h4208,F, 0,16'h0000,0,  16'h0000,16'h0000);
      add(0,0,0,16'h0000,F, 0,16'h0000,0,  16'h0000,16'h0000);
      // mask holds bit 0 back, offered after unmask
      add(0,0,0,16'h0101,16'hFFFE, 0,16'h0000,0, 16'h0101,16'h0000);
      add(0,0,0,16'h0101,16'hFFFE, 1,16'h0100,8, 16'h0101,16'h0000);
      add(0,0,0,16'h0101,F,        1,16'h0100,8, 16'h0101,16'h0000);
      add(0,0,1,16'h0101,F,        0,16'h0000,0, 16'h0001,16'h0000);
      add(0,0,0,16'h0101,F,        1,16'h0001,0, 16'h0001,16'h0000);
      add(0,0,1,16'h0101,F,        0,16'h0000,0, 16'h0000,16'h0000);
      add(0,0,0,16'h0000,F,        0,16'h0000,0, 16'h0000,16'h0000);
      // collisions on bit 2
      add(0,0,0,16'h0004,F, 0,16'h0000,0, 16'h0004,16'h0000);
      add(0,0,0,16'h0000,F, 1,16'h0004,2, 16'h0004,16'h0000);
      add(0,0,0,16'h0004,F, 1,16'h0004,2, 16'h0004,16'h0004);
      add(0,0,0,16'h0000,F, 1,16'h0004,2, 16'h0004,16'h0000);
      add(0,0,1,16'h0004,F, 0,16'h0000,0, 16'h0004,16'h0000);
      add(0,0,0,16'h0000,F, 1,16'h0004,2, 16'h0004,16'h0000);
      add(0,0,1,16'h0000,F, 0,16'h0000,0, 16'h0000,16'h0000);
      add(0,0,0,16'h0000,F, 0,16'h0000,0, 16'h0000,16'h0000);
      // clear_all during offer of index 7 beats a rise on bit 1
      add(0,0,0,16'h0080,F, 0,16'h0000,0, 16'h0080,16'h0000);
      add(0,0,0,16'h0000,F, 1,16'h0080,7, 16'h0080,16'h0000);
      add(0,1,0,16'h0002,F, 0,16'h0000,0, 16'h0000,16'h0000);
      add(0,0,0,16'h0002,F, 0,16'h0000,0, 16'h0000,16'h0000);
      add(0,0,0,16'h0000,F, 0,16'h0000,0, 16'h0000,16'h0000);
      add(0,0,0,16'h0000,F, 0,16'h0000,0, 16'h0000,16'h0000);
      // reset mid-offer; a line high after reset counts as a rise
      add(0,0,0,16'h1000,F, 0,16'h0000,0,  16'h1000,16'h0000);
      add(0,0,0,16'h1000,F, 1,16'h1000,12, 16'h1000,16'h0000);
      add(1,0,0,16'h1000,F, 0,16'h0000,0,  16'h0000,16'h0000);
      add(0,0,0,16'h1000,F, 0,16'h0000,0,  16'h1000,16'h0000);
      add(0,0,0,16'h0000,F, 1,16'h1000,12, 16'h1000,16'h0000);
      add(0,0,1,16'h0000,F, 0,16'h0000,0,  16'h0000,16'h0000);

      foreach (vecs[i]) begin
         @(negedge clk);
         rst       = vecs[i].rst;
         clear_all = vecs[i].clr;
         irq_ready = vecs[i].rdy;
         event_in  = vecs[i].ev;
         mask      = vecs[i].msk;
         @(posedge clk);
         #1;
         chk_all(i, vecs[i].e_valid, vecs[i].e_oh, vecs[i].e_idx, vecs[i].e_pend, vecs[i].e_ovf);
      end

      // Hand sequence: bounded wait for an offer on bit 10, then an
      // overflow pulse that must last exactly one cycle, then accept.
      @(negedge clk);
      rst = 1'b0; clear_all = 1'b0; irq_ready = 1'b0; mask = F;
      event_in = 16'h0400;
      got = 1'b0;
      for (int c = 0; c < 10 && !got; c++) begin
         @(posedge clk);
         #1;
         if (irq_valid) got = 1'b1;
      end
      n_vec++;
      if (!got) begin
         n_err++;
         $display("FAIL vec 100 wait_valid: got timeout expected irq_valid within 10 cycles");
      end
      chk_all(101, 1'b1, 16'h0400, 4'd10, 16'h0400, 16'h0000);

      @(negedge clk); event_in = 16'h0000;
      @(posedge clk); #1;
      chk_all(102, 1'b1, 16'h0400, 4'd10, 16'h0400, 16'h0000);

      @(negedge clk); event_in = 16'h0400;
      @(posedge clk); #1;
      chk_all(103, 1'b1, 16'h0400, 4'd10, 16'h0400, 16'h0400);

      @(negedge clk);
      @(posedge clk); #1;
      chk_all(104, 1'b1, 16'h0400, 4'd10, 16'h0400, 16'h0000);

      @(negedge clk); irq_ready = 1'b1;
      @(posedge clk); #1;
      chk_all(105, 1'b0, 16'h0000, 4'd0, 16'h0000, 16'h0000);

      @(negedge clk); irq_ready = 1'b0; event_in = 16'h0000;
      @(posedge clk); #1;
      chk_all(106, 1'b0, 16'h0000, 4'd0, 16'h0000, 16'h0000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
